// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (A = ALU, B = load/mem), the arbiter and the register-file write port.
// The master drives the requests and observes the readies and the write port. The slave is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg_addr;
  logic [DATA_W-1:0] write_reg_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, RegWrite, write_reg_addr, write_reg_data
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, RegWrite, write_reg_addr, write_reg_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Sole owner of the register-file write port: it zero-sweeps x1..x(NREGS-1) after reset, then round-robins A/B writebacks.
// Writes appear 1 cycle after the handshake. Each requester waits on valid/ready. Readies stay low during the sweep.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int NREGS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 init_done
);
  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic {GRANT_A, GRANT_B} grant_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              init_done_q, init_done_d;
  logic              a_rdy, b_rdy;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    init_addr_d  = init_addr_q;
    regwrite_d   = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    init_done_d  = init_done_q;
    a_rdy        = 1'b0;
    b_rdy        = 1'b0;

    case (state_q)
      INIT: begin
        regwrite_d  = 1'b1;
        waddr_d     = init_addr_q;
        wdata_d     = '0;
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (init_addr_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // A wins a tie only when B had the previous grant, so sustained ties alternate.
        a_rdy = bus.a_valid & (~bus.b_valid | (last_grant_q == GRANT_B));
        b_rdy = bus.b_valid & (~bus.a_valid | (last_grant_q == GRANT_A));
        if (a_rdy) begin
          last_grant_d = GRANT_A;
          regwrite_d   = (bus.a_addr != '0);
          waddr_d      = bus.a_addr;
          wdata_d      = bus.a_data;
        end else if (b_rdy) begin
          last_grant_d = GRANT_B;
          regwrite_d   = (bus.b_addr != '0);
          waddr_d      = bus.b_addr;
          wdata_d      = bus.b_data;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      last_grant_q <= GRANT_B;
      init_addr_q  <= ADDR_W'(1);
      regwrite_q   <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      init_addr_q  <= init_addr_d;
      regwrite_q   <= regwrite_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      init_done_q  <= init_done_d;
    end
  end

  assign bus.a_ready        = a_rdy;
  assign bus.b_ready        = b_rdy;
  assign bus.RegWrite       = regwrite_q;
  assign bus.write_reg_addr = waddr_q;
  assign bus.write_reg_data = wdata_q;
  assign init_done          = init_done_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model is checked every cycle, and literal expectations pin the model.
module tb_regfile_wb_arbiter;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic reset;
  logic init_done;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(64)) bus();

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(64), .NREGS(NREGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sweep counter, a "next tie goes to A" flag and the predicted write port.
  bit          m_ok = 1'b0;
  bit          m_run;
  bit          m_pref_a;
  int          m_next;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  bit          m_done;

  always @(posedge clk) begin : model
    bit ga, gb;
    ga = m_run && bus.a_valid && (!bus.b_valid || m_pref_a);
    gb = m_run && bus.b_valid && !ga;
    if (reset) begin
      m_ok = 1'b1; m_run = 1'b0; m_pref_a = 1'b1; m_next = 1;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_done = 1'b0;
    end else if (!m_run) begin
      m_we = 1'b1; m_addr = 5'(m_next); m_data = '0;
      if (m_next == NREGS - 1) begin
        m_run = 1'b1; m_done = 1'b1;
      end
      m_next++;
    end else if (ga) begin
      m_we = (bus.a_addr != 0); m_addr = bus.a_addr; m_data = bus.a_data; m_pref_a = 1'b0;
    end else if (gb) begin
      m_we = (bus.b_addr != 0); m_addr = bus.b_addr; m_data = bus.b_data; m_pref_a = 1'b1;
    end else begin
      m_we = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    bit ea, eb;
    if (m_ok) begin
      ea = m_run && bus.a_valid && (!bus.b_valid || m_pref_a);
      eb = m_run && bus.b_valid && !ea;
      chk("cmp_a_ready", bus.a_ready, ea);
      chk("cmp_b_ready", bus.b_ready, eb);
      chk("cmp_regwrite", bus.RegWrite, m_we);
      chk("cmp_addr", bus.write_reg_addr, m_addr);
      chk("cmp_data", bus.write_reg_data, m_data);
      chk("cmp_init_done", init_done, m_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_addr", bus.write_reg_addr, 0);
    chk("rst_data", bus.write_reg_data, 0);
    chk("rst_init_done", init_done, 0);
  endtask

  task automatic sweep_check(input bit hold_valids);
    int n;
    n = 1;
    if (hold_valids) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'd9;  bus.a_data = 64'h99;
      bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 64'hAA;
    end
    for (int i = 0; i < 33; i++) begin
      step();
      if (i == 10) begin
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
      end
      #2;
      if (hold_valids && i < 10) begin
        chk("sweep_a_ready", bus.a_ready, 0);
        chk("sweep_b_ready", bus.b_ready, 0);
      end
      if (bus.RegWrite) begin
        chk("sweep_addr", bus.write_reg_addr, 64'(n));
        chk("sweep_data", bus.write_reg_data, 0);
        n++;
      end
      if (i < 30) chk("sweep_init_done_low", init_done, 0);
    end
    chk("sweep_count", 64'(n - 1), 31);
    chk("sweep_init_done", init_done, 1);
    chk("sweep_idle", bus.RegWrite, 0);
  endtask

  initial begin : stim
    bit found;
    reset = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    step();
    step();
    reset = 1'b0;
    #2;
    check_reset_vals();

    // Zero sweep with both requesters pushing from the start.
    sweep_check(1'b1);

    // Single A write.
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 64'hDEAD;
    #1;
    chk("t2_a_ready", bus.a_ready, 1);
    step();
    bus.a_valid = 1'b0;
    #2;
    chk("t2_we", bus.RegWrite, 1);
    chk("t2_addr", bus.write_reg_addr, 5);
    chk("t2_data", bus.write_reg_data, 64'hDEAD);
    step();
    #2;
    chk("t2_we_off", bus.RegWrite, 0);

    // B write to x0: handshake completes, no write, payload still latched.
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 64'hFF;
    #1;
    chk("t4_b_ready", bus.b_ready, 1);
    step();
    bus.b_valid = 1'b0;
    #2;
    chk("t4_we", bus.RegWrite, 0);
    chk("t4_addr", bus.write_reg_addr, 0);
    chk("t4_data", bus.write_reg_data, 64'hFF);

    // Sustained tie with B as last winner: grants alternate A,B,A,B.
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 64'h11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 64'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_a_ready", bus.a_ready, 64'(i % 2 == 0));
      chk("t3_b_ready", bus.b_ready, 64'(i % 2 == 1));
      step();
      if (i == 3) begin
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
      end
      #2;
      chk("t3_we", bus.RegWrite, 1);
      chk("t3_addr", bus.write_reg_addr, (i % 2 == 0) ? 64'd3 : 64'd4);
      chk("t3_data", bus.write_reg_data, (i % 2 == 0) ? 64'h11 : 64'h22);
    end

    // B alone for three cycles: back-to-back writes.
    for (int i = 0; i < 3; i++) begin
      bus.b_valid = 1'b1; bus.b_addr = 5'(7 + i); bus.b_data = 64'(8'h70 + i);
      #1;
      chk("t6_b_ready", bus.b_ready, 1);
      step();
      if (i == 2) bus.b_valid = 1'b0;
      #2;
      chk("t6_we", bus.RegWrite, 1);
      chk("t6_addr", bus.write_reg_addr, 64'(7 + i));
      chk("t6_data", bus.write_reg_data, 64'(8'h70 + i));
    end

    // Reset in the middle of a sweep restarts it from x1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      #2;
      if (bus.RegWrite && bus.write_reg_addr == 5'd12) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reached_addr12", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    check_reset_vals();
    sweep_check(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
